// File: rtl/gsensor_sequencer_pkg.sv
// Shared SPI parameter header for the G-sensor sequencer: field widths, register
// addresses, command words and FSM state encoding.
package gsensor_sequencer_pkg;

  localparam int unsigned SI_DataL = 15;
  localparam int unsigned SO_DataL = 7;

  localparam logic [5:0] RegDataFormat = 6'h31;
  localparam logic [5:0] RegBwRate     = 6'h2C;
  localparam logic [5:0] RegPowerCtl   = 6'h2D;
  localparam logic [5:0] RegDataX0     = 6'h32;

  // {R/W, MB, addr[5:0], data[7:0]}
  localparam logic [SI_DataL:0] InitDataFormat = {1'b0, 1'b0, RegDataFormat, 8'h40};
  localparam logic [SI_DataL:0] InitBwRate     = {1'b0, 1'b0, RegBwRate, 8'h09};
  localparam logic [SI_DataL:0] InitPowerCtl   = {1'b0, 1'b0, RegPowerCtl, 8'h08};

  typedef enum logic [2:0] {
    INIT_XFER,
    INIT_GAP,
    WAIT,
    RD_XFER,
    RD_GAP,
    PUBLISH
  } seqState_e;

  // Single-byte read of data register DATAX0 + idx.
  function automatic logic [SI_DataL:0] readCmd(input logic [2:0] idx);
    readCmd = {1'b1, 1'b0, RegDataX0 + {3'b000, idx}, 8'h00};
  endfunction

endpackage

// File: rtl/gsensor_sequencer_if.sv
// SPI shifter handshake between the sequencer (master) and the shifter (slave).
interface gsensor_sequencer_if;
  import gsensor_sequencer_pkg::*;

  logic                oSPI_GO;
  logic [SI_DataL:0]   oP2S_DATA;
  logic                iSPI_END;
  logic [SO_DataL:0]   iS2P_DATA;

  modport master (output oSPI_GO, output oP2S_DATA, input iSPI_END, input iS2P_DATA);
  modport slave  (input oSPI_GO, input oP2S_DATA, output iSPI_END, output iS2P_DATA);
endinterface

// File: rtl/gsensor_init_rom.sv
// Init write table: three configuration words indexed 0..2, combinational.
module gsensor_init_rom
  import gsensor_sequencer_pkg::*;
(
  input  logic [1:0]        iIDX,
  output logic [SI_DataL:0] oWORD
);

  always_comb begin
    oWORD = '0;
    case (iIDX)
      2'd0:    oWORD = InitDataFormat;
      2'd1:    oWORD = InitBwRate;
      2'd2:    oWORD = InitPowerCtl;
      default: oWORD = '0;
    endcase
  end

endmodule

// File: rtl/gsensor_sequencer.sv
// Sequences the accelerometer init writes, then periodic 6-byte X/Y/Z read bursts
// over the SPI shifter, with per-transfer timeout.
module gsensor_sequencer
  import gsensor_sequencer_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 8,
  parameter int unsigned SAMPLE_DIV = 20000,
  parameter int unsigned TIMEOUT    = 31
) (
  input  logic                      iSPI_CLK,
  input  logic                      iRSTN,
  input  logic                      iEN,
  gsensor_sequencer_if.master       spi,
  output logic                      oINIT_DONE,
  output logic [15:0]               oDATA_X,
  output logic [15:0]               oDATA_Y,
  output logic [15:0]               oDATA_Z,
  output logic                      oDATA_VALID,
  output logic                      oERR
);

  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT + 1);
  localparam int unsigned DivW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(SAMPLE_DIV - 1);

  seqState_e         state;
  logic [2:0]        idx;
  logic [GapW-1:0]   gapCnt;
  logic [ToW-1:0]    toCnt;
  logic [DivW-1:0]   divCnt;
  logic              armed;
  logic              abort;
  logic [5:0][7:0]   rdBytes;
  logic [1:0]        romIdx;
  logic [SI_DataL:0] romWord;
  logic              sampleTick;

  // Leaving INIT_GAP normally needs the next word; a retry reuses the current one.
  assign romIdx     = (state == INIT_GAP && !abort) ? idx[1:0] + 2'd1 : idx[1:0];
  assign sampleTick = oINIT_DONE && iEN && (divCnt == DivLast);

  gsensor_init_rom u_init_rom (
    .iIDX  (romIdx),
    .oWORD (romWord)
  );

  always_ff @(posedge iSPI_CLK) begin
    if (!iRSTN) begin
      state         <= INIT_XFER;
      idx           <= '0;
      gapCnt        <= '0;
      toCnt         <= '0;
      divCnt        <= '0;
      armed         <= 1'b0;
      abort         <= 1'b0;
      rdBytes       <= '0;
      spi.oSPI_GO   <= 1'b0;
      spi.oP2S_DATA <= '0;
      oINIT_DONE    <= 1'b0;
      oDATA_X       <= '0;
      oDATA_Y       <= '0;
      oDATA_Z       <= '0;
      oDATA_VALID   <= 1'b0;
      oERR          <= 1'b0;
    end else begin
      oDATA_VALID <= 1'b0;
      if (oINIT_DONE) divCnt <= (divCnt == DivLast) ? '0 : divCnt + DivW'(1);
      // Ticks outside WAIT belong to a running burst and are dropped.
      armed <= armed | (sampleTick && state == WAIT);

      case (state)
        INIT_XFER, RD_XFER: begin
          if (!spi.oSPI_GO) begin
            // Only reachable on the first cycle after reset.
            spi.oSPI_GO   <= 1'b1;
            spi.oP2S_DATA <= (state == INIT_XFER) ? romWord : readCmd(idx);
            toCnt         <= '0;
          end else if (spi.iSPI_END || toCnt == ToLast) begin
            spi.oSPI_GO <= 1'b0;
            gapCnt      <= '0;
            abort       <= !spi.iSPI_END;
            if (!spi.iSPI_END) oERR <= 1'b1;
            state       <= (state == INIT_XFER) ? INIT_GAP : RD_GAP;
          end else begin
            toCnt <= toCnt + ToW'(1);
          end
        end

        INIT_GAP, RD_GAP: begin
          if (state == RD_GAP && gapCnt == '0 && !abort) rdBytes[idx] <= spi.iS2P_DATA;
          gapCnt <= gapCnt + GapW'(1);
          if (gapCnt == GapLast) begin
            abort <= 1'b0;
            toCnt <= '0;
            if (state == INIT_GAP) begin
              if (!abort && idx == 3'd2) begin
                oINIT_DONE <= 1'b1;
                state      <= WAIT;
              end else begin
                if (!abort) idx <= idx + 3'd1;
                spi.oSPI_GO   <= 1'b1;
                spi.oP2S_DATA <= romWord;
                state         <= INIT_XFER;
              end
            end else if (abort) begin
              state <= WAIT;
            end else if (idx == 3'd5) begin
              state <= PUBLISH;
            end else begin
              idx           <= idx + 3'd1;
              spi.oSPI_GO   <= 1'b1;
              spi.oP2S_DATA <= readCmd(idx + 3'd1);
              state         <= RD_XFER;
            end
          end
        end

        WAIT: begin
          if (armed) begin
            armed         <= 1'b0;
            idx           <= '0;
            toCnt         <= '0;
            spi.oSPI_GO   <= 1'b1;
            spi.oP2S_DATA <= readCmd(3'd0);
            state         <= RD_XFER;
          end
        end

        PUBLISH: begin
          oDATA_X     <= {rdBytes[1], rdBytes[0]};
          oDATA_Y     <= {rdBytes[3], rdBytes[2]};
          oDATA_Z     <= {rdBytes[5], rdBytes[4]};
          oDATA_VALID <= 1'b1;
          state       <= WAIT;
        end

        default: state <= INIT_XFER;
      endcase
    end
  end

endmodule

// File: tb/tb_gsensor_sequencer.sv
// Scoreboard bench for gsensor_sequencer: a behavioural shifter answers transfers,
// monitors compare issued command words and published samples against queued expectations.
module tb_gsensor_sequencer;
  import gsensor_sequencer_pkg::*;

  localparam int unsigned Gap = 8;
  localparam int unsigned Div = 64;
  localparam int unsigned Tmo = 31;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        initDone, dataValid, err;
  logic [15:0] dx, dy, dz;

  gsensor_sequencer_if spi ();

  gsensor_sequencer #(
    .GAP_CYCLES (Gap),
    .SAMPLE_DIV (Div),
    .TIMEOUT    (Tmo)
  ) dut (
    .iSPI_CLK    (clk),
    .iRSTN       (rstn),
    .iEN         (en),
    .spi         (spi),
    .oINIT_DONE  (initDone),
    .oDATA_X     (dx),
    .oDATA_Y     (dy),
    .oDATA_Z     (dz),
    .oDATA_VALID (dataValid),
    .oERR        (err)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] expWord[$];
  logic [47:0] expSample[$];
  int          endDelay = 17;
  logic [7:0]  seed = 8'h00;
  logic [5:0]  withholdAddr = 6'h00;
  int          riseCnt = 0;
  int          validCnt = 0;
  int          lastHighLen = 0;
  int          cycle = 0;
  int          lastB200 = -1;
  bit          periodOn = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pushBurst(input int n);
    for (int i = 0; i < n; i++) expWord.push_back(16'hB200 + 16'(i * 256));
  endtask

  // Behavioural shifter: END after endDelay GO cycles; read byte k (addr 0x32+k) = 0x11*(k+1)^seed.
  int goCnt = 0;
  always @(negedge clk) begin
    if (!spi.oSPI_GO) begin
      goCnt = 0;
      spi.iSPI_END = 1'b0;
    end else begin
      goCnt++;
      spi.iSPI_END = (goCnt == endDelay) && (spi.oP2S_DATA[13:8] != withholdAddr);
    end
    spi.iS2P_DATA = ((spi.oP2S_DATA[15:8] - 8'hB1) * 8'h11) ^ seed;
  end

  // Monitor: GO rises, gap lengths, burst period, published samples.
  logic        goPrev = 1'b0;
  logic        validPrev = 1'b0;
  int          lowCnt = 0;
  int          highCnt = 0;
  logic [15:0] w;
  always @(negedge clk) begin
    cycle++;
    if (spi.oSPI_GO) begin
      if (!goPrev) begin
        riseCnt++;
        if (expWord.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_go: got word 0x%0h, expected no transfer", spi.oP2S_DATA);
        end else begin
          w = expWord.pop_front();
          check("go_word", spi.oP2S_DATA, w);
          if (w != 16'h3140 && w != 16'hB200) check("gap_len", lowCnt, Gap);
          if (w == 16'hB200) begin
            if (periodOn && lastB200 >= 0) check("burst_period", cycle - lastB200, Div);
            lastB200 = cycle;
          end
        end
      end
      highCnt = goPrev ? highCnt + 1 : 1;
    end else begin
      if (goPrev) begin
        lastHighLen = highCnt;
        lowCnt = 0;
      end
      lowCnt++;
    end
    goPrev = spi.oSPI_GO;

    if (validPrev) check("valid_1cyc", dataValid, 1'b0);
    if (dataValid && !validPrev) begin
      validCnt++;
      if (expSample.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got %h/%h/%h, expected no publish", dx, dy, dz);
      end else begin
        check("sample_xyz", {dx, dy, dz}, expSample.pop_front());
      end
    end
    validPrev = dataValid;
  end

  task automatic waitInit();
    for (int i = 0; i < 400 && !initDone; i++) tick();
    check("init_done", initDone, 1'b1);
    check("init_words_left", expWord.size(), 0);
  endtask

  task automatic waitValid(input string name);
    int v0;
    v0 = validCnt;
    for (int i = 0; i < 300 && validCnt == v0; i++) tick();
    check(name, validCnt, v0 + 1);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_go"}, spi.oSPI_GO, 1'b0);
    check({tag, "_init_done"}, initDone, 1'b0);
    check({tag, "_valid"}, dataValid, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_x"}, dx, 16'h0);
    check({tag, "_y"}, dy, 16'h0);
    check({tag, "_z"}, dz, 16'h0);
  endtask

  initial begin
    int r0;
    int v1;
    repeat (3) tick();
    checkAllZero("reset");

    // Init sequence with END 17 cycles into each transfer.
    expWord.push_back(16'h3140);
    expWord.push_back(16'h2C09);
    expWord.push_back(16'h2D08);
    rstn = 1'b1;
    waitInit();

    // Two regular bursts, 64 cycles apart.
    en = 1'b1;
    endDelay = 1;
    periodOn = 1'b1;
    pushBurst(6);
    expSample.push_back({16'h2211, 16'h4433, 16'h6655});
    waitValid("burst1_done");
    seed = 8'h80;
    pushBurst(6);
    expSample.push_back({16'hA291, 16'hC4B3, 16'hE6D5});
    waitValid("burst2_done");

    // Timeout on the third read (addr 0x34).
    withholdAddr = 6'h34;
    pushBurst(3);
    for (int i = 0; i < 200 && !err; i++) tick();
    check("err_set", err, 1'b1);
    check("timeout_go_len", lastHighLen, Tmo);
    check("x_kept", dx, 16'hA291);
    check("y_kept", dy, 16'hC4B3);
    check("z_kept", dz, 16'hE6D5);
    check("abort_words_left", expWord.size(), 0);
    withholdAddr = 6'h00;
    seed = 8'h0F;
    pushBurst(6);
    expSample.push_back({16'h2D1E, 16'h4B3C, 16'h695A});
    waitValid("burst_after_timeout");
    check("err_sticky", err, 1'b1);

    // iEN low before a tick: no transfers at all.
    periodOn = 1'b0;
    en = 1'b0;
    r0 = riseCnt;
    repeat (150) tick();
    check("no_go_when_disabled", riseCnt, r0);

    // iEN dropped right after a burst starts: it completes and publishes once.
    en = 1'b1;
    seed = 8'h00;
    pushBurst(6);
    expSample.push_back({16'h2211, 16'h4433, 16'h6655});
    for (int i = 0; i < 200 && riseCnt == r0; i++) tick();
    check("burst_started", riseCnt, r0 + 1);
    en = 1'b0;
    waitValid("burst_en_low_done");
    v1 = validCnt;
    repeat (150) tick();
    check("single_publish", validCnt, v1);
    check("en_low_words_left", expWord.size(), 0);

    // Reset in the middle of a read transfer.
    en = 1'b1;
    endDelay = 20;
    r0 = riseCnt;
    pushBurst(1);
    for (int i = 0; i < 200 && riseCnt == r0; i++) tick();
    repeat (3) tick();
    check("go_before_reset", spi.oSPI_GO, 1'b1);
    rstn = 1'b0;
    tick();
    checkAllZero("midxfer_reset");
    endDelay = 17;
    expWord.push_back(16'h3140);
    expWord.push_back(16'h2C09);
    expWord.push_back(16'h2D08);
    tick();
    rstn = 1'b1;
    waitInit();
    en = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
